// File: rtl/qos_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : qos_pkg                                                       |
// | Purpose  : Shared widths, FSM state encoding and helpers for the QoS     |
// |            output scheduler (qos_out_scheduler / qos_pick).              |
// | Contents : NUM_BUF, CNT_W, DATA_W, RD_W, ID_W, state_t, onehot_to_id     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package qos_pkg;

   localparam int NUM_BUF = 4;   // number of QoS buffers
   localparam int CNT_W   = 3;   // occupancy field width per buffer
   localparam int DATA_W  = 4;   // packet width
   localparam int RD_W    = 8;   // per-buffer read counter width
   localparam int ID_W    = 2;   // buffer index width

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARB  = 2'd1,
      POP  = 2'd2
   } state_t;

   // One-hot to binary index; an all-zero vector maps to 0.
   function automatic logic [ID_W-1:0] onehot_to_id(input logic [NUM_BUF-1:0] oh);
      logic [ID_W-1:0] id;
      id = '0;
      for (int i = 0; i < NUM_BUF; i++) begin
         if (oh[i]) id = ID_W'(i);
      end
      return id;
   endfunction

endpackage
`default_nettype wire

// File: rtl/qos_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : qos_pick                                                      |
// | Purpose  : Combinational arbiter. Class order starved > full > non-empty,|
// |            highest buffer index wins inside a class.                     |
// | Ports    : counts  in  NUM_BUF*CNT_W  occupancy {bf4..bf1}               |
// |            waits   in  NUM_BUF*CNT_W  wait counters {bf4..bf1}           |
// |            grant   out NUM_BUF        one-hot winner                     |
// |            valid   out 1              at least one non-empty buffer      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module qos_pick
   import qos_pkg::*;
#(
   parameter int DEPTH        = 6,
   parameter int STARVE_LIMIT = 3
) (
   input  logic [NUM_BUF*CNT_W-1:0] counts,
   input  logic [NUM_BUF*CNT_W-1:0] waits,
   output logic [NUM_BUF-1:0]       grant,
   output logic                     valid
);

   localparam logic [CNT_W-1:0] c_depth  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] c_starve = CNT_W'(STARVE_LIMIT);

   logic [NUM_BUF-1:0] w_busy;
   logic [NUM_BUF-1:0] w_full;
   logic [NUM_BUF-1:0] w_starved;
   logic [NUM_BUF-1:0] w_cand;

   generate
      for (genvar i = 0; i < NUM_BUF; i++) begin : g_flags
         logic [CNT_W-1:0] w_cnt;
         logic [CNT_W-1:0] w_wait;
         assign w_cnt        = counts[i*CNT_W +: CNT_W];
         assign w_wait       = waits[i*CNT_W +: CNT_W];
         assign w_busy[i]    = (w_cnt != '0);
         // Out-of-range occupancy (> DEPTH) is treated as full.
         assign w_full[i]    = (w_cnt >= c_depth);
         assign w_starved[i] = w_busy[i] && (w_wait >= c_starve);
      end
   endgenerate

   always_comb begin
      w_cand = (w_starved != '0) ? w_starved :
               (w_full    != '0) ? w_full    : w_busy;
      grant  = '0;
      // Later (higher) indices overwrite earlier ones: highest index wins.
      for (int i = 0; i < NUM_BUF; i++) begin
         if (w_cand[i]) grant = NUM_BUF'(1) << i;
      end
      valid  = |w_busy;
   end

endmodule
`default_nettype wire

// File: rtl/qos_out_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : qos_out_scheduler                                             |
// | Purpose  : Once per service period picks one of four buffers, pops one   |
// |            packet through a req/ack handshake, presents it on            |
// |            output_data and keeps saturating per-buffer read counters.    |
// | Ports    : clk, rst (async active-low), start (level enable)             |
// |            bf_count[11:0] in   occupancy {bf4,bf3,bf2,bf1}               |
// |            pop_req[3:0]   out  one-hot pop request                       |
// |            pop_ack, pop_data[3:0] in  pop handshake / popped packet      |
// |            output_data[3:0], output_valid, grant_id[1:0] out             |
// |            read_cnt[31:0] out  {bf4..bf1} reads, 8 b each, saturating    |
// |            ack_err        out  sticky ack-timeout flag                   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module qos_out_scheduler
   import qos_pkg::*;
#(
   parameter int PERIOD_CYCLES = 50_000_000,
   parameter int DEPTH         = 6,
   parameter int STARVE_LIMIT  = 3,
   parameter int ACK_TIMEOUT   = 15
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [NUM_BUF*CNT_W-1:0] bf_count,
   output logic [NUM_BUF-1:0]       pop_req,
   input  logic                     pop_ack,
   input  logic [DATA_W-1:0]        pop_data,
   output logic [DATA_W-1:0]        output_data,
   output logic                     output_valid,
   output logic [ID_W-1:0]          grant_id,
   output logic [NUM_BUF*RD_W-1:0]  read_cnt,
   output logic                     ack_err
);

   localparam int TMR_W = $clog2(PERIOD_CYCLES);
   localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TMR_W-1:0] c_tmr_last = TMR_W'(PERIOD_CYCLES - 1);
   localparam logic [TO_W-1:0]  c_to_last  = TO_W'(ACK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] c_starve   = CNT_W'(STARVE_LIMIT);
   localparam logic [RD_W-1:0]  c_rd_max   = {RD_W{1'b1}};

   state_t                     state_q,    state_d;
   logic [TMR_W-1:0]           timer_q,    timer_d;
   logic [TO_W-1:0]            to_q,       to_d;
   logic [NUM_BUF-1:0]         grant_q,    grant_d;
   logic [ID_W-1:0]            grant_id_q, grant_id_d;
   logic [NUM_BUF*CNT_W-1:0]   wait_q,     wait_d;
   logic [NUM_BUF*RD_W-1:0]    rd_q,       rd_d;
   logic [DATA_W-1:0]          out_data_q, out_data_d;
   logic                       out_vld_q,  out_vld_d;
   logic                       ack_err_q,  ack_err_d;

   logic                       w_tick;
   logic [NUM_BUF-1:0]         w_pick;
   logic                       w_pick_vld;

   qos_pick #(
      .DEPTH        (DEPTH),
      .STARVE_LIMIT (STARVE_LIMIT)
   ) u_pick (
      .counts (bf_count),
      .waits  (wait_q),
      .grant  (w_pick),
      .valid  (w_pick_vld)
   );

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      to_d       = to_q;
      grant_d    = grant_q;
      grant_id_d = grant_id_q;
      wait_d     = wait_q;
      rd_d       = rd_q;
      out_data_d = out_data_q;
      out_vld_d  = 1'b0;
      ack_err_d  = ack_err_q;

      // Service timer: free-runs while enabled, tick on the wrap cycle.
      w_tick = start && (timer_q == c_tmr_last);
      if (!start)      timer_d = '0;
      else if (w_tick) timer_d = '0;
      else             timer_d = timer_q + 1'b1;

      case (state_q)
         IDLE: begin
            if (w_tick) state_d = ARB;
         end
         ARB: begin
            to_d = '0;
            for (int i = 0; i < NUM_BUF; i++) begin
               if (w_pick[i] || (bf_count[i*CNT_W +: CNT_W] == '0))
                  wait_d[i*CNT_W +: CNT_W] = '0;
               else if (wait_q[i*CNT_W +: CNT_W] < c_starve)
                  wait_d[i*CNT_W +: CNT_W] = wait_q[i*CNT_W +: CNT_W] + 1'b1;
            end
            if (w_pick_vld) begin
               grant_d    = w_pick;
               grant_id_d = onehot_to_id(w_pick);
               state_d    = POP;
            end else begin
               state_d    = IDLE;
            end
         end
         POP: begin
            if (pop_ack) begin
               out_data_d = pop_data;
               out_vld_d  = 1'b1;
               if (rd_q[grant_id_q*RD_W +: RD_W] != c_rd_max)
                  rd_d[grant_id_q*RD_W +: RD_W] = rd_q[grant_id_q*RD_W +: RD_W] + 1'b1;
               state_d    = IDLE;
            end else if (to_q == c_to_last) begin
               ack_err_d  = 1'b1;
               state_d    = IDLE;
            end else begin
               to_d       = to_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         to_q       <= '0;
         grant_q    <= '0;
         grant_id_q <= '0;
         wait_q     <= '0;
         rd_q       <= '0;
         out_data_q <= '0;
         out_vld_q  <= 1'b0;
         ack_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         to_q       <= to_d;
         grant_q    <= grant_d;
         grant_id_q <= grant_id_d;
         wait_q     <= wait_d;
         rd_q       <= rd_d;
         out_data_q <= out_data_d;
         out_vld_q  <= out_vld_d;
         ack_err_q  <= ack_err_d;
      end
   end

   // Decoded from flops only, so reset removes the request asynchronously.
   assign pop_req      = (state_q == POP) ? grant_q : '0;
   assign output_data  = out_data_q;
   assign output_valid = out_vld_q;
   assign grant_id     = grant_id_q;
   assign read_cnt     = rd_q;
   assign ack_err      = ack_err_q;

endmodule
`default_nettype wire
